// File: rtl/keypad_pkg.sv
// Shared constants and FSM state type for the keypad entry controller.
package keypad_pkg;

  localparam logic [4:0] SYM_BLANK = 5'd16;
  localparam logic [4:0] SYM_ERR   = 5'd17;
  localparam logic [4:0] KEY_ENTER = 5'd10;
  localparam logic [4:0] KEY_CLEAR = 5'd11;

  localparam logic [1:0] DESP_FIRST  = 2'b00;
  localparam logic [1:0] DESP_SECOND = 2'b01;
  localparam logic [1:0] DESP_THIRD  = 2'b10;
  localparam logic [1:0] DESP_ERR    = 2'b11;

  typedef enum logic [2:0] {IDLE, D1, D2, D3, DONE, ERR} state_t;

endpackage

// File: rtl/idle_timer.sv
// Clearable idle counter with a terminal-count flag at LIMIT-1.
// Only instantiated when KEYPAD_TIMEOUT_EN is defined.
module idle_timer #(
  parameter int unsigned LIMIT = 50000000,
  parameter int unsigned W     = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + W'(1);
  end

  assign tc = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer driving the cdu display shift register.
// Define KEYPAD_TIMEOUT_EN to enable the inactivity auto-clear timer.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned TMR_W          = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic [4:0] digito,
  output logic [1:0] desp,
  output logic       shift,
  output logic [9:0] num,
  output logic       num_valid,
  output logic [1:0] count,
  output logic       err
);

  state_t     state, state_n;
  logic [9:0] acc, acc_n, num_n;
  logic [4:0] digito_n;
  logic [1:0] desp_n, count_n;
  logic       shift_n, num_valid_n, err_n;
  logic       blank_pend;
  logic       is_digit, is_enter, is_clear, in_entry, accepted, clear_req;
  logic       timeout;

  assign is_digit = key_valid && (key_code <= 5'd9);
  assign is_enter = key_valid && (key_code == KEY_ENTER);
  assign is_clear = key_valid && (key_code == KEY_CLEAR);
  assign in_entry = (state == D1) || (state == D2) || (state == D3);
  assign accepted = is_clear || (is_digit && state != ERR) || (is_enter && in_entry);
  // The post-reset blank and the timeout both act as CLEAR but yield to any accepted key.
  assign clear_req = is_clear || (!accepted && (blank_pend || timeout));

`ifdef KEYPAD_TIMEOUT_EN
  logic tmr_clr;
  assign tmr_clr = accepted || !in_entry || timeout;

  idle_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TMR_W)
  ) u_idle_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (in_entry),
    .tc  (timeout)
  );
`else
  // Parameters stay in the interface for drop-in compatibility; no timer is built.
  assign timeout = (TIMEOUT_CYCLES == 0) && (TMR_W == 0) && 1'b0;
`endif

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    num_n       = num;
    digito_n    = digito;
    desp_n      = desp;
    count_n     = count;
    err_n       = err;
    shift_n     = 1'b0;
    num_valid_n = 1'b0;
    if (clear_req) begin
      shift_n  = 1'b1;
      desp_n   = DESP_FIRST;
      digito_n = SYM_BLANK;
      acc_n    = '0;
      count_n  = 2'd0;
      err_n    = 1'b0;
      state_n  = IDLE;
    end else if (accepted && is_digit) begin
      shift_n  = 1'b1;
      digito_n = key_code;
      case (state)
        IDLE, DONE: begin
          desp_n  = DESP_FIRST;
          acc_n   = 10'(key_code);
          count_n = 2'd1;
          state_n = D1;
        end
        D1: begin
          desp_n  = DESP_SECOND;
          acc_n   = acc * 10'd10 + 10'(key_code);
          count_n = 2'd2;
          state_n = D2;
        end
        D2: begin
          desp_n  = DESP_THIRD;
          acc_n   = acc * 10'd10 + 10'(key_code);
          count_n = 2'd3;
          state_n = D3;
        end
        default: begin
          desp_n   = DESP_ERR;
          digito_n = SYM_ERR;
          err_n    = 1'b1;
          count_n  = 2'd0;
          state_n  = ERR;
        end
      endcase
    end else if (accepted && is_enter) begin
      num_n       = acc;
      num_valid_n = 1'b1;
      state_n     = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      num        <= '0;
      digito     <= SYM_BLANK;
      desp       <= DESP_FIRST;
      count      <= 2'd0;
      err        <= 1'b0;
      shift      <= 1'b0;
      num_valid  <= 1'b0;
      blank_pend <= 1'b1;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      num        <= num_n;
      digito     <= digito_n;
      desp       <= desp_n;
      count      <= count_n;
      err        <= err_n;
      shift      <= shift_n;
      num_valid  <= num_valid_n;
      blank_pend <= 1'b0;
    end
  end

endmodule
